seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative radix-2 restoring divider for the MIPS DIV/DIVU path. It produces one quotient bit per cycle using a WIDTH+1-bit trial subtraction.
- Subtraction is the complementary operation to the CPU's carry-lookahead adder chain.
- Sits beside the ALU and writes the HI/LO-destined remainder/quotient. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2)
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- sign  in  1  1=signed (DIV), 0=unsigned (DIVU); captured with start
- dividend  in  WIDTH  captured with start
- divisor  in  WIDTH  captured with start
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse, result valid
- quotient  out  WIDTH  registered result (LO)
- remainder  out  WIDTH  registered result (HI)
- div_zero  out  1  registered; divisor was 0 for the last completed operation

Behaviour:
- Reset: on rst=1 at a clock edge, go to IDLE. busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0. This applies at any state; an in-flight operation is discarded with no done.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - On start=1, capture sign, operand magnitudes and sign bits. In signed mode, negative operands are two's-complement negated; unsigned mode uses operands as-is.
  - Also capture div_zero_pending = (divisor==0).
  - Clear the partial remainder; counter=0; go to CALC. busy=1 from the next cycle.
- CALC, once per cycle:
  - Shift {rem,quo} left 1, bringing in the dividend MSB.
  - Trial = rem − divisor_mag at WIDTH+1 bits.
  - If trial is non-negative, rem=trial and quotient LSB=1; else quotient LSB=0.
  - After WIDTH iterations (counter==WIDTH−1), go to FIX.
- FIX:
  - Signed mode: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend is negative. This truncates toward zero, and the remainder takes the dividend's sign.
  - Register quotient, remainder and div_zero; go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; go to IDLE.
- Latency:
  - start sampled at edge E0.
  - busy high in cycles E0+1 … E0+WIDTH+1.
  - done high in cycle E0+WIDTH+2 (34 cycles for WIDTH=32).
- Outputs hold their values until the next FIX or rst.
- A start received during CALC or FIX is ignored, with no effect on the operation in flight.
- A start received in the DONE cycle is also ignored (busy=0 there, but the state is not IDLE).
- The requester must keep start asserted or re-assert it after done.
- Divide by zero: no trap; full latency. Results are quotient = all ones and remainder = dividend (raw input, unsigned interpretation), with div_zero=1. This applies for both sign settings; the FIX negations are suppressed.
- Signed overflow (−2^(WIDTH−1) / −1): quotient = 0x80000000, remainder = 0, with no flag (natural wrap).
- Magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), held correctly in WIDTH unsigned bits.

Optional Feature:
- Macro: SEQ_DIVIDER_ZERO_FAST_EN.
- When defined: if the divisor is 0 at start, IDLE goes directly to FIX with the div-zero results. Done asserts in cycle E0+2 and busy is high only in cycle E0+1.
- When undefined: divide by zero takes the full WIDTH+2 latency, as above.
- Result values are identical in both builds.

Test Plan:
- Unsigned 100/7, start at cycle 0 -> done=1 at cycle 34 only, quotient=14, remainder=2, div_zero=0; busy=1 in cycles 1..33.
- Signed 0xFFFFFFF9 (−7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / 0xFFFFFFFE (−2) -> quotient=0xFFFFFFFD, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned same operands -> quotient=0, remainder=0x80000000.
- 5/0 (sign=1) -> quotient=0xFFFFFFFF, remainder=5, div_zero=1. Done at cycle 34, or at cycle 2 with SEQ_DIVIDER_ZERO_FAST_EN.
- Start 1000/3, rst=1 at cycle 10 -> next cycle busy=0, outputs 0, no done. Then 9/4 -> quotient=2, remainder=1 at 34 cycles after its start.
- Start 50/5, re-pulse start with 8/8 at cycle 5 and again at the DONE cycle -> the single done carries quotient=10, remainder=0; the re-pulses produce no second operation.

Source files
------------

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//
// Iterative radix-2 restoring divider serving the MIPS DIV/DIVU path. One
// quotient bit is produced per cycle with a WIDTH+1-bit trial subtraction,
// then a final fix-up cycle applies the signed-mode negations. The pipeline
// stalls while o_busy is high; o_done pulses for one cycle with the result.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous, active-high reset
//   i_start      operation request, honoured only in IDLE
//   i_sign       1 = signed (DIV), 0 = unsigned (DIVU); captured with start
//   i_dividend   dividend, captured with start
//   i_divisor    divisor, captured with start
//   o_busy       high while an operation is in flight
//   o_done       one-cycle pulse, results valid
//   o_quotient   registered quotient (LO)
//   o_remainder  registered remainder (HI)
//   o_div_zero   registered; divisor was zero for the last completed operation
//
// Optional build macro:
//   SEQ_DIVIDER_ZERO_FAST_EN  when defined, a zero divisor skips the iterative
//                             phase and goes straight to the fix-up cycle.
//                             Result values are identical either way.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;

  logic [CNT_W-1:0]  r_count;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_divisorMag;
  logic [WIDTH-1:0]  r_rawDividend;
  logic              r_dividendNeg;
  logic              r_divisorNeg;
  logic              r_divZeroPending;
  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_divZero;

  logic              w_startAccept;
  logic              w_divisorZero;
  logic              w_dividendNeg;
  logic              w_divisorNeg;
  logic [WIDTH-1:0]  w_dividendMag;
  logic [WIDTH-1:0]  w_divisorMag;
  logic [WIDTH:0]    w_shifted;
  logic [WIDTH:0]    w_trial;
  logic              w_trialOk;
  logic [WIDTH-1:0]  w_quoFixed;
  logic [WIDTH-1:0]  w_remFixed;

  // Operand conditioning at start. Only signed mode treats the MSB as a sign;
  // the magnitude of the most negative value (2^(WIDTH-1)) still fits in
  // WIDTH unsigned bits, so no extra width is needed.
  assign w_startAccept = (r_state == ST_IDLE) && i_start;
  assign w_divisorZero = (i_divisor == '0);
  assign w_dividendNeg = i_sign & i_dividend[WIDTH-1];
  assign w_divisorNeg  = i_sign & i_divisor[WIDTH-1];
  assign w_dividendMag = w_dividendNeg ? ('0 - i_dividend) : i_dividend;
  assign w_divisorMag  = w_divisorNeg  ? ('0 - i_divisor)  : i_divisor;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and trial-subtract. The shifted value is always below twice
  // the divisor, so the MSB of the WIDTH+1-bit difference is a clean borrow.
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_divisorMag};
  assign w_trialOk = ~w_trial[WIDTH];

  // Sign fix-up: quotient truncates toward zero, remainder follows the
  // dividend's sign. A zero divisor bypasses this and reports all-ones over
  // the raw dividend regardless of mode.
  always_comb begin
    w_quoFixed = r_quo;
    w_remFixed = r_rem;
    if (r_divZeroPending) begin
      w_quoFixed = '1;
      w_remFixed = r_rawDividend;
    end else begin
      if (r_dividendNeg ^ r_divisorNeg) begin
        w_quoFixed = '0 - r_quo;
      end
      if (r_dividendNeg) begin
        w_remFixed = '0 - r_rem;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and status outputs. Starts outside IDLE (including the DONE
  // cycle, where busy is already low) are deliberately ignored.
  always_comb begin
    w_stateNext = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
          w_stateNext = w_divisorZero ? ST_FIX : ST_CALC;
`else
          w_stateNext = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        o_busy = 1'b1;
        if (r_count == CNT_W'(WIDTH - 1)) begin
          w_stateNext = ST_FIX;
        end
      end
      ST_FIX: begin
        o_busy      = 1'b1;
        w_stateNext = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand capture in IDLE, one quotient bit per CALC cycle,
  // result registration in FIX. Reset discards any in-flight operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count          <= '0;
      r_rem            <= '0;
      r_quo            <= '0;
      r_divisorMag     <= '0;
      r_rawDividend    <= '0;
      r_dividendNeg    <= 1'b0;
      r_divisorNeg     <= 1'b0;
      r_divZeroPending <= 1'b0;
      r_quotient       <= '0;
      r_remainder      <= '0;
      r_divZero        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_startAccept) begin
            r_count          <= '0;
            r_rem            <= '0;
            r_quo            <= w_dividendMag;
            r_divisorMag     <= w_divisorMag;
            r_rawDividend    <= i_dividend;
            r_dividendNeg    <= w_dividendNeg;
            r_divisorNeg     <= w_divisorNeg;
            r_divZeroPending <= w_divisorZero;
          end
        end
        ST_CALC: begin
          r_rem   <= w_trialOk ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], w_trialOk};
          r_count <= r_count + 1'b1;
        end
        ST_FIX: begin
          r_quotient  <= w_quoFixed;
          r_remainder <= w_remFixed;
          r_divZero   <= r_divZeroPending;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_div_zero  = r_divZero;

endmodule
